// File: rtl/test_monitor.sv
// -----------------------------------------------------------------------------
// test_monitor
//
// Watches the register-file writeback ports of NUM_HARTS cores running a
// self-checking test program. Each hart flags completion by writing 1 to
// DONE_REG, its verdict to PASS_REG and its current test number to TNUM_REG.
// The monitor waits SETTLE_CYC edges after the completion write, samples the
// pass flag and records a per-hart PASS/FAIL. A global watchdog aborts the run
// if any hart is still busy after TIMEOUT_CYC edges.
//
// Ports
//   clk          : clock, all state on its rising edge
//   rst          : synchronous active-high reset
//   wb_we        : per-hart register-file write strobe
//   wb_addr      : per-hart destination index, hart h at [5h+4:5h]
//   wb_data      : per-hart write data, hart h at [DATA_W*h +: DATA_W]
//   done         : all harts terminal, or watchdog expired (sticky)
//   pass         : done with every hart PASS and no timeout
//   fail         : any hart FAIL, or watchdog expired
//   timeout      : watchdog expired while a hart was still running
//   fail_hart    : first failing hart (or lowest busy hart on timeout)
//   fail_testnum : test number reported by that hart
// -----------------------------------------------------------------------------
module test_monitor #(
    parameter int         DATA_W      = 32,
    parameter int         NUM_HARTS   = 2,
    parameter logic [4:0] DONE_REG    = 5'd26,
    parameter logic [4:0] PASS_REG    = 5'd27,
    parameter logic [4:0] TNUM_REG    = 5'd3,
    parameter int         SETTLE_CYC  = 5,
    parameter int         TIMEOUT_CYC = 2500
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NUM_HARTS-1:0]                              wb_we,
    input  logic [5*NUM_HARTS-1:0]                            wb_addr,
    input  logic [DATA_W*NUM_HARTS-1:0]                       wb_data,
    output logic                                              done,
    output logic                                              pass,
    output logic                                              fail,
    output logic                                              timeout,
    output logic [$clog2(NUM_HARTS > 1 ? NUM_HARTS : 2)-1:0]  fail_hart,
    output logic [DATA_W-1:0]                                 fail_testnum
);

    localparam int          HART_W       = $clog2(NUM_HARTS > 1 ? NUM_HARTS : 2);
    localparam logic [23:0] TIMEOUT_VAL  = 24'(TIMEOUT_CYC);
    localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  SETTLE_LOAD  = 8'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SETTLE,
        ST_PASS,
        ST_FAIL
    } state_t;

    // Per-hart status gathered from the generate loop
    logic [NUM_HARTS-1:0] live_d;       // hart still RUN/SETTLE after this edge
    logic [NUM_HARTS-1:0] enter_fail;   // hart moves into FAIL on this edge
    logic [NUM_HARTS-1:0] is_pass_q;
    logic [NUM_HARTS-1:0] is_fail_q;
    logic [NUM_HARTS-1:0] is_term_q;
    logic [DATA_W-1:0]    tnum_d_arr [NUM_HARTS];

    // Global state
    logic [23:0]       cyc_q, cyc_d;
    logic              timeout_q, timeout_d;
    logic              fail_seen_q, fail_seen_d;
    logic [HART_W-1:0] fail_hart_q, fail_hart_d;
    logic [DATA_W-1:0] fail_testnum_q, fail_testnum_d;
    logic              found;
    logic              halt;

    // Once the run is decided everything freezes until reset.
    assign halt = (&is_term_q) | timeout_q;

    for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
        state_t            state_q, state_d;
        logic [7:0]        cnt_q, cnt_d;
        logic [DATA_W-1:0] done_sh_q, done_sh_d;
        logic [DATA_W-1:0] pass_sh_q, pass_sh_d;
        logic [DATA_W-1:0] tnum_sh_q, tnum_sh_d;
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
        logic              active;
        logic              wr_ok;
        logic              wr_done;
        logic              wr_pass;
        logic              wr_tnum;

        assign addr    = wb_addr[5*gi +: 5];
        assign data    = wb_data[DATA_W*gi +: DATA_W];
        // Shadows only follow the hart while it is still undecided.
        assign active  = !halt && (state_q == ST_RUN || state_q == ST_SETTLE);
        assign wr_ok   = active && wb_we[gi] && (addr != 5'd0);
        assign wr_done = wr_ok && (addr == DONE_REG);
        assign wr_pass = wr_ok && (addr == PASS_REG);
        assign wr_tnum = wr_ok && (addr == TNUM_REG);

        always_comb begin
            done_sh_d = wr_done ? data : done_sh_q;
            pass_sh_d = wr_pass ? data : pass_sh_q;
            tnum_sh_d = wr_tnum ? data : tnum_sh_q;
            state_d   = state_q;
            cnt_d     = cnt_q;
            if (active) begin
                case (state_q)
                    ST_RUN: begin
                        if (wr_done && (data == DATA_W'(1))) begin
                            state_d = ST_SETTLE;
                            cnt_d   = SETTLE_LOAD;
                        end
                    end
                    ST_SETTLE: begin
                        // pass_sh_d, not _q: a pass write on the final edge counts.
                        if (cnt_q == 8'd0) begin
                            state_d = (pass_sh_d == DATA_W'(1)) ? ST_PASS : ST_FAIL;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= ST_RUN;
                cnt_q     <= 8'd0;
                done_sh_q <= '0;
                pass_sh_q <= '0;
                tnum_sh_q <= '0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                done_sh_q <= done_sh_d;
                pass_sh_q <= pass_sh_d;
                tnum_sh_q <= tnum_sh_d;
            end
        end

        assign live_d[gi]     = (state_d == ST_RUN) || (state_d == ST_SETTLE);
        assign enter_fail[gi] = (state_q != ST_FAIL) && (state_d == ST_FAIL);
        assign is_pass_q[gi]  = (state_q == ST_PASS);
        assign is_fail_q[gi]  = (state_q == ST_FAIL);
        assign is_term_q[gi]  = (state_q == ST_PASS) || (state_q == ST_FAIL);
        assign tnum_d_arr[gi] = tnum_sh_d;
    end

    always_comb begin
        cyc_d          = cyc_q;
        timeout_d      = timeout_q;
        fail_seen_d    = fail_seen_q;
        fail_hart_d    = fail_hart_q;
        fail_testnum_d = fail_testnum_q;
        found          = 1'b0;
        if (!halt) begin
            if (cyc_q != TIMEOUT_VAL) begin
                cyc_d = cyc_q + 24'd1;
            end
            // A hart finishing on the expiry edge itself is not a timeout.
            if ((cyc_q == TIMEOUT_LAST) && (|live_d)) begin
                timeout_d = 1'b1;
            end
            if (!fail_seen_q) begin
                // Ascending scan: lowest index wins a same-edge tie.
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (!found && enter_fail[h]) begin
                        found          = 1'b1;
                        fail_hart_d    = HART_W'(h);
                        fail_testnum_d = tnum_d_arr[h];
                    end
                end
                if (found) begin
                    fail_seen_d = 1'b1;
                end else if (timeout_d) begin
                    // No real failure: blame the lowest hart still busy.
                    for (int h = 0; h < NUM_HARTS; h++) begin
                        if (!found && live_d[h]) begin
                            found          = 1'b1;
                            fail_hart_d    = HART_W'(h);
                            fail_testnum_d = tnum_d_arr[h];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q          <= 24'd0;
            timeout_q      <= 1'b0;
            fail_seen_q    <= 1'b0;
            fail_hart_q    <= '0;
            fail_testnum_q <= '0;
        end else begin
            cyc_q          <= cyc_d;
            timeout_q      <= timeout_d;
            fail_seen_q    <= fail_seen_d;
            fail_hart_q    <= fail_hart_d;
            fail_testnum_q <= fail_testnum_d;
        end
    end

    assign done         = halt;
    assign pass         = halt && !timeout_q && (&is_pass_q);
    assign fail         = (|is_fail_q) | timeout_q;
    assign timeout      = timeout_q;
    assign fail_hart    = fail_hart_q;
    assign fail_testnum = fail_testnum_q;

endmodule

// File: tb/tb_test_monitor.sv
// -----------------------------------------------------------------------------
// tb_test_monitor
//
// Directed bench for test_monitor with two harts, SETTLE_CYC=5 and
// TIMEOUT_CYC=100. Edges are numbered from 1 = first edge with rst low.
// -----------------------------------------------------------------------------
module tb_test_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb_we;
    logic [9:0]  wb_addr;
    logic [63:0] wb_data;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [0:0]  fail_hart;
    logic [31:0] fail_testnum;

    int checks = 0;
    int passed = 0;

    test_monitor #(
        .DATA_W      (32),
        .NUM_HARTS   (2),
        .DONE_REG    (5'd26),
        .PASS_REG    (5'd27),
        .TNUM_REG    (5'd3),
        .SETTLE_CYC  (5),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .fail_hart    (fail_hart),
        .fail_testnum (fail_testnum)
    );

    always #5 clk = ~clk;

    // Present a write for hart h on the coming edge.
    task automatic set_wr(input int h, input logic [4:0] a, input logic [31:0] d);
        wb_we[h]          = 1'b1;
        wb_addr[5*h +: 5] = a;
        wb_data[32*h +: 32] = d;
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        wb_we = '0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wb_we = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_wr(0, 5'd27, 32'd1);
        set_wr(1, 5'd27, 32'd1);
        tick();
        set_wr(0, 5'd26, 32'd1);
        set_wr(1, 5'd26, 32'd1);
        tick();
        rst = 1'b0;
        checks++; if (done !== 1'b0) $display("FAIL rst_done got=%0b exp=0", done); else passed++;
        checks++; if (pass !== 1'b0) $display("FAIL rst_pass got=%0b exp=0", pass); else passed++;
        checks++; if (fail !== 1'b0) $display("FAIL rst_fail got=%0b exp=0", fail); else passed++;
        checks++; if (timeout !== 1'b0) $display("FAIL rst_timeout got=%0b exp=0", timeout); else passed++;
        checks++; if (fail_hart !== 1'b0) $display("FAIL rst_fail_hart got=%0d exp=0", fail_hart); else passed++;
        checks++; if (fail_testnum !== 32'd0) $display("FAIL rst_fail_testnum got=%0d exp=0", fail_testnum); else passed++;
        // Writes seen during reset must not have started a settle.
        repeat (7) tick();
        checks++; if (done !== 1'b0) $display("FAIL rst_writes_dropped_done got=%0b exp=0", done); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_all_pass();
        do_reset();
        set_wr(0, 5'd27, 32'd1); set_wr(1, 5'd27, 32'd1); tick();   // e1
        set_wr(0, 5'd26, 32'd1); tick();                           // e2
        set_wr(1, 5'd26, 32'd1); tick();                           // e3
        repeat (4) tick();                                         // e7
        checks++; if (done !== 1'b0) $display("FAIL allpass_early_done got=%0b exp=0", done); else passed++;
        tick();                                                    // e8
        checks++; if (done !== 1'b1) $display("FAIL allpass_done got=%0b exp=1", done); else passed++;
        checks++; if (pass !== 1'b1) $display("FAIL allpass_pass got=%0b exp=1", pass); else passed++;
        checks++; if (fail !== 1'b0) $display("FAIL allpass_fail got=%0b exp=0", fail); else passed++;
        checks++; if (timeout !== 1'b0) $display("FAIL allpass_timeout got=%0b exp=0", timeout); else passed++;
        $display("test_all_pass done");
    endtask

    task automatic test_fail_testnum();
        do_reset();
        set_wr(1, 5'd3, 32'd7);  set_wr(0, 5'd27, 32'd1); tick();  // e1
        set_wr(1, 5'd27, 32'd0); set_wr(0, 5'd26, 32'd1); tick();  // e2
        set_wr(1, 5'd26, 32'd1); tick();                           // e3
        repeat (4) tick();                                         // e7
        checks++; if (fail !== 1'b0) $display("FAIL h1fail_early_fail got=%0b exp=0", fail); else passed++;
        tick();                                                    // e8
        checks++; if (fail !== 1'b1) $display("FAIL h1fail_fail got=%0b exp=1", fail); else passed++;
        checks++; if (pass !== 1'b0) $display("FAIL h1fail_pass got=%0b exp=0", pass); else passed++;
        checks++; if (done !== 1'b1) $display("FAIL h1fail_done got=%0b exp=1", done); else passed++;
        checks++; if (fail_hart !== 1'b1) $display("FAIL h1fail_hart got=%0d exp=1", fail_hart); else passed++;
        checks++; if (fail_testnum !== 32'd7) $display("FAIL h1fail_testnum got=%0d exp=7", fail_testnum); else passed++;
        $display("test_fail_testnum done");
    endtask

    task automatic test_settle_edge();
        // Pass flag written on the final settle edge is taken into account.
        do_reset();
        set_wr(0, 5'd26, 32'd1); set_wr(1, 5'd27, 32'd1); tick();  // e1
        set_wr(1, 5'd26, 32'd1); tick();                           // e2
        repeat (3) tick();                                         // e5
        set_wr(0, 5'd27, 32'd1); tick();                           // e6
        checks++; if (fail !== 1'b0) $display("FAIL edge_ok_fail got=%0b exp=0", fail); else passed++;
        tick();                                                    // e7
        checks++; if (done !== 1'b1) $display("FAIL edge_ok_done got=%0b exp=1", done); else passed++;
        checks++; if (pass !== 1'b1) $display("FAIL edge_ok_pass got=%0b exp=1", pass); else passed++;
        // One edge later is too late: hart 0 has already failed.
        do_reset();
        set_wr(0, 5'd26, 32'd1); set_wr(1, 5'd27, 32'd1); tick();  // e1
        set_wr(1, 5'd26, 32'd1); tick();                           // e2
        repeat (4) tick();                                         // e6
        checks++; if (fail !== 1'b1) $display("FAIL edge_late_fail got=%0b exp=1", fail); else passed++;
        checks++; if (fail_hart !== 1'b0) $display("FAIL edge_late_hart got=%0d exp=0", fail_hart); else passed++;
        set_wr(0, 5'd27, 32'd1); tick();                           // e7
        checks++; if (done !== 1'b1) $display("FAIL edge_late_done got=%0b exp=1", done); else passed++;
        checks++; if (pass !== 1'b0) $display("FAIL edge_late_pass got=%0b exp=0", pass); else passed++;
        $display("test_settle_edge done");
    endtask

    task automatic test_timeout();
        do_reset();
        set_wr(0, 5'd27, 32'd1); set_wr(1, 5'd3, 32'd5); tick();   // e1
        set_wr(0, 5'd26, 32'd1); tick();                           // e2
        repeat (97) tick();                                        // e99
        checks++; if (timeout !== 1'b0) $display("FAIL to_early_timeout got=%0b exp=0", timeout); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL to_early_done got=%0b exp=0", done); else passed++;
        tick();                                                    // e100
        checks++; if (timeout !== 1'b1) $display("FAIL to_timeout got=%0b exp=1", timeout); else passed++;
        checks++; if (fail !== 1'b1) $display("FAIL to_fail got=%0b exp=1", fail); else passed++;
        checks++; if (done !== 1'b1) $display("FAIL to_done got=%0b exp=1", done); else passed++;
        checks++; if (pass !== 1'b0) $display("FAIL to_pass got=%0b exp=0", pass); else passed++;
        checks++; if (fail_hart !== 1'b1) $display("FAIL to_hart got=%0d exp=1", fail_hart); else passed++;
        checks++; if (fail_testnum !== 32'd5) $display("FAIL to_testnum got=%0d exp=5", fail_testnum); else passed++;
        // Frozen after done: later writes change nothing.
        set_wr(1, 5'd3, 32'd9); tick();
        set_wr(1, 5'd26, 32'd1); tick();
        repeat (6) tick();
        checks++; if (fail_testnum !== 32'd5) $display("FAIL to_hold_testnum got=%0d exp=5", fail_testnum); else passed++;
        checks++; if (done !== 1'b1) $display("FAIL to_hold_done got=%0b exp=1", done); else passed++;
        $display("test_timeout done");
    endtask

    task automatic test_timeout_same_edge();
        // Last hart goes terminal exactly on edge 100: no timeout.
        do_reset();
        set_wr(0, 5'd27, 32'd1); set_wr(1, 5'd27, 32'd1); tick();  // e1
        set_wr(0, 5'd26, 32'd1); tick();                           // e2
        repeat (92) tick();                                        // e94
        set_wr(1, 5'd26, 32'd1); tick();                           // e95
        repeat (4) tick();                                         // e99
        checks++; if (done !== 1'b0) $display("FAIL tse_early_done got=%0b exp=0", done); else passed++;
        tick();                                                    // e100
        checks++; if (timeout !== 1'b0) $display("FAIL tse_timeout got=%0b exp=0", timeout); else passed++;
        checks++; if (pass !== 1'b1) $display("FAIL tse_pass got=%0b exp=1", pass); else passed++;
        $display("test_timeout_same_edge done");
    endtask

    task automatic test_ignore_and_midreset();
        do_reset();
        set_wr(0, 5'd26, 32'd2); set_wr(1, 5'd3, 32'd6); tick();   // e1: not a completion
        set_wr(0, 5'd0, 32'd1);  set_wr(1, 5'd26, 32'd1); tick();  // e2: x0 ignored
        set_wr(0, 5'd0, 32'd1); tick();                            // e3
        repeat (4) tick();                                         // e7
        checks++; if (fail !== 1'b1) $display("FAIL ign_fail got=%0b exp=1", fail); else passed++;
        checks++; if (fail_hart !== 1'b1) $display("FAIL ign_hart got=%0d exp=1", fail_hart); else passed++;
        checks++; if (fail_testnum !== 32'd6) $display("FAIL ign_testnum got=%0d exp=6", fail_testnum); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL ign_done got=%0b exp=0", done); else passed++;
        set_wr(0, 5'd27, 32'd1); tick();                           // e8
        set_wr(0, 5'd26, 32'd1); tick();                           // e9: hart 0 settling
        tick();                                                    // e10
        rst = 1'b1; tick(); rst = 1'b0;                            // e11: reset mid-settle
        checks++; if (fail !== 1'b0) $display("FAIL mrst_fail got=%0b exp=0", fail); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL mrst_done got=%0b exp=0", done); else passed++;
        checks++; if (fail_hart !== 1'b0) $display("FAIL mrst_hart got=%0d exp=0", fail_hart); else passed++;
        checks++; if (fail_testnum !== 32'd0) $display("FAIL mrst_testnum got=%0d exp=0", fail_testnum); else passed++;
        // Hart 0 back in RUN with cleared pass flag: completion now fails.
        set_wr(0, 5'd26, 32'd1); tick();                           // f1
        repeat (4) tick();                                         // f5
        checks++; if (fail !== 1'b0) $display("FAIL mrst_early_fail got=%0b exp=0", fail); else passed++;
        tick();                                                    // f6
        checks++; if (fail !== 1'b1) $display("FAIL mrst_refail got=%0b exp=1", fail); else passed++;
        checks++; if (fail_hart !== 1'b0) $display("FAIL mrst_refail_hart got=%0d exp=0", fail_hart); else passed++;
        $display("test_ignore_and_midreset done");
    endtask

    task automatic test_same_edge_fail();
        do_reset();
        set_wr(0, 5'd3, 32'd4);  set_wr(1, 5'd3, 32'd9);  tick();  // e1
        set_wr(0, 5'd26, 32'd1); set_wr(1, 5'd26, 32'd1); tick();  // e2
        repeat (4) tick();                                         // e6
        checks++; if (fail !== 1'b0) $display("FAIL tie_early_fail got=%0b exp=0", fail); else passed++;
        tick();                                                    // e7
        checks++; if (done !== 1'b1) $display("FAIL tie_done got=%0b exp=1", done); else passed++;
        checks++; if (fail_hart !== 1'b0) $display("FAIL tie_hart got=%0d exp=0", fail_hart); else passed++;
        checks++; if (fail_testnum !== 32'd4) $display("FAIL tie_testnum got=%0d exp=4", fail_testnum); else passed++;
        $display("test_same_edge_fail done");
    endtask

    task automatic test_first_fail_sticks();
        do_reset();
        set_wr(0, 5'd3, 32'd4);  set_wr(1, 5'd3, 32'd9); tick();   // e1
        set_wr(1, 5'd26, 32'd1); tick();                           // e2
        set_wr(0, 5'd26, 32'd1); tick();                           // e3
        repeat (4) tick();                                         // e7
        checks++; if (fail_hart !== 1'b1) $display("FAIL first_hart got=%0d exp=1", fail_hart); else passed++;
        checks++; if (fail_testnum !== 32'd9) $display("FAIL first_testnum got=%0d exp=9", fail_testnum); else passed++;
        tick();                                                    // e8
        checks++; if (done !== 1'b1) $display("FAIL first_done got=%0b exp=1", done); else passed++;
        checks++; if (fail_hart !== 1'b1) $display("FAIL first_hold_hart got=%0d exp=1", fail_hart); else passed++;
        checks++; if (fail_testnum !== 32'd9) $display("FAIL first_hold_testnum got=%0d exp=9", fail_testnum); else passed++;
        $display("test_first_fail_sticks done");
    endtask

    initial begin
        rst     = 1'b1;
        wb_we   = '0;
        wb_addr = '0;
        wb_data = '0;
        test_reset();
        test_all_pass();
        test_fail_testnum();
        test_settle_edge();
        test_timeout();
        test_timeout_same_edge();
        test_ignore_and_midreset();
        test_same_edge_fail();
        test_first_fail_sticks();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
